mem_bus_master: RTL and testbench

- Upstream of the 24-bit word memory space: converts CPU-side byte-addressed load/store requests (valid/ready) into the memory space's two-phase word protocol.
- Memory protocol: registered address phase with active-low write strobe; write data and active-low byte mask one cycle later; read data returned one cycle after the address phase under active-low output enable.
- Handles byte/half/word sizes, load sign/zero extension, and misaligned accesses, split into two word accesses with 22-bit word-address wrap-around.

---
 rtl/mem_bus_master.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_bus_master.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_master.sv
// Byte-addressed load/store front end for the 24-bit word memory: issues one or two
// registered address/data phase pairs per request and merges/extends load data.
module mem_bus_master #(
    parameter logic [21:0] IDLE_ADDR = 22'h000000
) (
    input  logic        clock,
    input  logic        resetlo,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_write,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [21:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_wlo,
    output logic        mem_olo
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_A1   = 3'd1,
        S_D1   = 3'd2,
        S_A2   = 3'd3,
        S_D2   = 3'd4
    } state_t;

    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        case (size)
            2'd0:    size_to_nbytes = 3'd1;
            2'd1:    size_to_nbytes = 3'd2;
            default: size_to_nbytes = 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] byte_enables(input logic [2:0] nb, input logic [1:0] off);
        logic [7:0] base;
        case (nb)
            3'd1:    base = 8'h01;
            3'd2:    base = 8'h03;
            default: base = 8'h0F;
        endcase
        byte_enables = base << off;
    endfunction

    // Right-justify the addressed bytes of the two-word window, then extend to 32 bits.
    function automatic logic [31:0] load_extend(input logic [63:0] dw, input logic [1:0] off,
                                                input logic [2:0] nb, input logic sgn);
        logic [31:0] sh;
        sh = 32'(dw >> {off, 3'b000});
        case (nb)
            3'd1:    load_extend = {{24{sgn & sh[7]}}, sh[7:0]};
            3'd2:    load_extend = {{16{sgn & sh[15]}}, sh[15:0]};
            default: load_extend = sh;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic        accept_s;
    logic        rd0_capture_s;
    logic [2:0]  req_nb_s;

    logic [23:0] addr_q;
    logic [2:0]  nb_q;
    logic        write_q;
    logic        signed_q;
    logic        split_q;
    logic [63:0] lanes_q;
    logic [7:0]  en_q;
    logic [31:0] rd0_q;

    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [21:0] mem_address_q, mem_address_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wmask_q, mem_wmask_d;
    logic        mem_wlo_q, mem_wlo_d;
    logic        mem_olo_q, mem_olo_d;

    assign req_nb_s = size_to_nbytes(req_size);

    // Sequencer: next state and the next value of every registered output.
    always_comb begin
        state_d       = state_q;
        accept_s      = 1'b0;
        rd0_capture_s = 1'b0;
        req_ready_d   = 1'b0;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = 32'h0000_0000;
        mem_address_d = IDLE_ADDR;
        mem_wdata_d   = 32'h0000_0000;
        mem_wmask_d   = 4'hF;
        mem_wlo_d     = 1'b1;
        mem_olo_d     = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept_s      = 1'b1;
                    state_d       = S_A1;
                    mem_address_d = req_addr[23:2];
                    mem_wlo_d     = ~req_write;
                end else begin
                    req_ready_d   = 1'b1;
                end
            end
            S_A1: begin
                state_d = S_D1;
                if (write_q) begin
                    mem_wdata_d = lanes_q[31:0];
                    mem_wmask_d = ~en_q[3:0];
                end else begin
                    mem_olo_d   = 1'b0;
                end
            end
            S_D1: begin
                if (split_q) begin
                    state_d       = S_A2;
                    rd0_capture_s = 1'b1;
                    mem_address_d = addr_q[23:2] + 22'd1;
                    mem_wlo_d     = ~write_q;
                end else begin
                    state_d       = S_IDLE;
                    req_ready_d   = 1'b1;
                    resp_valid_d  = 1'b1;
                    resp_rdata_d  = write_q ? 32'h0000_0000
                                  : load_extend({32'h0000_0000, mem_rdata}, addr_q[1:0], nb_q, signed_q);
                end
            end
            S_A2: begin
                state_d = S_D2;
                if (write_q) begin
                    mem_wdata_d = lanes_q[63:32];
                    mem_wmask_d = ~en_q[7:4];
                end else begin
                    mem_olo_d   = 1'b0;
                end
            end
            S_D2: begin
                state_d      = S_IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b1;
                resp_rdata_d = write_q ? 32'h0000_0000
                             : load_extend({mem_rdata, rd0_q}, addr_q[1:0], nb_q, signed_q);
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset forces the idle bus values.
    always_ff @(posedge clock or negedge resetlo) begin
        if (!resetlo) begin
            state_q       <= S_IDLE;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 32'h0000_0000;
            mem_address_q <= IDLE_ADDR;
            mem_wdata_q   <= 32'h0000_0000;
            mem_wmask_q   <= 4'hF;
            mem_wlo_q     <= 1'b1;
            mem_olo_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wmask_q   <= mem_wmask_d;
            mem_wlo_q     <= mem_wlo_d;
            mem_olo_q     <= mem_olo_d;
        end
    end

    // Request latch: lanes and enables are pre-shifted once at accept time.
    always_ff @(posedge clock or negedge resetlo) begin
        if (!resetlo) begin
            addr_q   <= 24'h00_0000;
            nb_q     <= 3'd4;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            split_q  <= 1'b0;
            lanes_q  <= 64'h0;
            en_q     <= 8'h00;
        end else if (accept_s) begin
            addr_q   <= req_addr;
            nb_q     <= req_nb_s;
            write_q  <= req_write;
            signed_q <= req_signed;
            split_q  <= (({2'b00, req_addr[1:0]} + {1'b0, req_nb_s}) > 4'd4);
            lanes_q  <= {32'h0000_0000, req_wdata} << {req_addr[1:0], 3'b000};
            en_q     <= byte_enables(req_nb_s, req_addr[1:0]);
        end
    end

    // Low word of a split load, held until the second data phase completes.
    always_ff @(posedge clock or negedge resetlo) begin
        if (!resetlo) begin
            rd0_q <= 32'h0000_0000;
        end else if (rd0_capture_s) begin
            rd0_q <= mem_rdata;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wmask   = mem_wmask_q;
    assign mem_wlo     = mem_wlo_q;
    assign mem_olo     = mem_olo_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: two-phase word memory model plus a byte-level reference model.
module tb_mem_bus_master;

    logic        clock = 1'b0;
    logic        resetlo;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [23:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata, resp_rdata, mem_wdata, mem_rdata;
    logic        resp_valid, mem_wlo, mem_olo;
    logic [21:0] mem_address;
    logic [3:0]  mem_wmask;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_bus_master dut (
        .clock(clock), .resetlo(resetlo),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_write(req_write), .req_signed(req_signed),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_wmask(mem_wmask), .mem_wlo(mem_wlo), .mem_olo(mem_olo)
    );

    // Memory model: a 1024-word window (top bit plus low 9 bits of the word address).
    logic [31:0] mem_q [1024];
    logic [21:0] mlat_q;
    logic        wpend_q = 1'b0;
    logic [31:0] mrd_q;
    logic        mem_clear = 1'b1;
    int          stray_q = 0;

    function automatic logic in_win(input logic [21:0] wa);
        return wa[20:9] == {12{wa[21]}};
    endfunction

    function automatic logic [9:0] widx(input logic [21:0] wa);
        return {wa[21], wa[8:0]};
    endfunction

    function automatic logic [31:0] merge_write(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [3:0] mask_n);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (!mask_n[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    always @(posedge clock) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem_q[i] <= 32'h0;
        end else if (wpend_q) begin
            if (in_win(mlat_q))
                mem_q[widx(mlat_q)] <= merge_write(mem_q[widx(mlat_q)], mem_wdata, mem_wmask);
            else if (mem_wmask != 4'hF)
                stray_q <= stray_q + 1;
        end
        mlat_q  <= mem_address;
        wpend_q <= ~mem_wlo;
        mrd_q   <= in_win(mem_address) ? mem_q[widx(mem_address)] : 32'hBAD0_BAD0;
    end

    assign mem_rdata = mem_olo ? 32'hA5A5_A5A5 : mrd_q;

    // Reference model: flat byte memory, 24-bit addresses wrap.
    logic [7:0] rmem [int unsigned];

    function automatic void ref_store(input logic [23:0] a, input int nb, input logic [31:0] wd);
        logic [23:0] ba;
        for (int i = 0; i < nb; i++) begin
            ba = a + 24'(i);
            rmem[{8'd0, ba}] = wd[8*i +: 8];
        end
    endfunction

    function automatic logic [31:0] ref_load(input logic [23:0] a, input int nb, input logic sg);
        logic [31:0] v;
        logic [23:0] ba;
        v = 32'h0;
        for (int i = 0; i < nb; i++) begin
            ba = a + 24'(i);
            v[8*i +: 8] = rmem.exists({8'd0, ba}) ? rmem[{8'd0, ba}] : 8'h00;
        end
        if (sg && v[8*nb-1]) for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    logic [21:0] s_addr  [1:8];
    logic [31:0] s_wdata [1:8];
    logic [3:0]  s_wmask [1:8];
    logic        s_wlo   [1:8];
    logic        s_olo   [1:8];
    logic [31:0] last_rd;
    int          last_lat;

    // Issue one request at the current negedge; return at the negedge of the resp_valid cycle.
    task automatic do_req(input logic [23:0] a, input logic [1:0] sz, input logic wr,
                          input logic sg, input logic [31:0] wd);
        int k;
        check("ready_at_issue", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_addr = a; req_size = sz;
        req_write = wr; req_signed = sg; req_wdata = wd;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_addr = 24'($urandom); req_wdata = $urandom; req_size = 2'($urandom);
        req_write = 1'($urandom); req_signed = 1'($urandom);
        last_lat = 99;
        last_rd  = 32'hxxxx_xxxx;
        k = 0;
        while (last_lat == 99 && k < 8) begin
            k++;
            @(negedge clock);
            s_addr[k] = mem_address; s_wdata[k] = mem_wdata; s_wmask[k] = mem_wmask;
            s_wlo[k] = mem_wlo; s_olo[k] = mem_olo;
            if (resp_valid) begin
                last_lat = k;
                last_rd  = resp_rdata;
            end
        end
        check("resp_timeout_or_latency", 32'(last_lat), 32'(last_lat == 99 ? 0 : last_lat));
    endtask

    task automatic op(input logic [23:0] a, input logic [1:0] sz, input logic wr,
                      input logic sg, input logic [31:0] wd);
        int nb;
        int exp_lat;
        logic [31:0] exp_rd;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        exp_lat = (int'(a[1:0]) + nb > 4) ? 5 : 3;
        exp_rd = wr ? 32'h0 : ref_load(a, nb, sg);
        if (wr) ref_store(a, nb, wd);
        do_req(a, sz, wr, sg, wd);
        check("latency", 32'(last_lat), 32'(exp_lat));
        check("resp_rdata", last_rd, exp_rd);
        check("ready_in_resp", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int cnt;
        int bad;
        logic [23:0] ba;
        logic [31:0] w;
        logic [23:0] ra;

        resetlo = 1'b0; req_valid = 1'b0; req_addr = 24'h0; req_size = 2'd0;
        req_write = 1'b0; req_signed = 1'b0; req_wdata = 32'h0;
        repeat (3) @(negedge clock);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_addr", 32'(mem_address), 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_wmask", 32'(mem_wmask), 32'hF);
        check("rst_wlo", 32'(mem_wlo), 32'd1);
        check("rst_olo", 32'(mem_olo), 32'd1);
        mem_clear = 1'b0;
        resetlo = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_hold_addr", 32'(mem_address), 32'h0);
        check("idle_hold_wlo", 32'(mem_wlo), 32'd1);
        check("idle_hold_resp", 32'(resp_valid), 32'd0);

        // Aligned word store then load.
        op(24'h000100, 2'd2, 1'b1, 1'b0, 32'hDEADBEEF);
        check("st_a1_addr", 32'(s_addr[1]), 32'h40);
        check("st_a1_wlo", 32'(s_wlo[1]), 32'd0);
        check("st_d1_wmask", 32'(s_wmask[2]), 32'h0);
        check("st_d1_wdata", s_wdata[2], 32'hDEADBEEF);
        check("st_d1_addr", 32'(s_addr[2]), 32'h0);
        op(24'h000100, 2'd2, 1'b0, 1'b0, 32'h0);
        check("ld_word", last_rd, 32'hDEADBEEF);

        // Byte loads, signed and unsigned.
        op(24'h000100, 2'd2, 1'b1, 1'b0, 32'h80FF1234);
        op(24'h000103, 2'd0, 1'b0, 1'b1, 32'h0);
        check("ld_byte_s", last_rd, 32'hFFFFFF80);
        op(24'h000103, 2'd0, 1'b0, 1'b0, 32'h0);
        check("ld_byte_u", last_rd, 32'h00000080);

        // Split half store.
        op(24'h000203, 2'd1, 1'b1, 1'b0, 32'h0000A5C3);
        check("split_a1_addr", 32'(s_addr[1]), 32'h80);
        check("split_w0_mask", 32'(s_wmask[2]), 32'h7);
        check("split_w0_byte", 32'(s_wdata[2][31:24]), 32'hC3);
        check("split_a2_addr", 32'(s_addr[3]), 32'h81);
        check("split_a2_wlo", 32'(s_wlo[3]), 32'd0);
        check("split_w1_mask", 32'(s_wmask[4]), 32'hE);
        check("split_w1_byte", 32'(s_wdata[4][7:0]), 32'hA5);
        check("split_lat", 32'(last_lat), 32'd5);

        // Wrap-around split load.
        op(24'hFFFFFC, 2'd2, 1'b1, 1'b0, 32'h11223344);
        op(24'h000000, 2'd2, 1'b1, 1'b0, 32'h55667788);
        op(24'hFFFFFE, 2'd2, 1'b0, 1'b0, 32'h0);
        check("wrap_a1_addr", 32'(s_addr[1]), 32'h3FFFFF);
        check("wrap_a2_addr", 32'(s_addr[3]), 32'h0);
        check("wrap_rdata", last_rd, 32'h77881122);

        // Single read of the stdio port.
        op(24'hFFFFFC, 2'd2, 1'b1, 1'b0, 32'h00000041);
        op(24'hFFFFFC, 2'd0, 1'b0, 1'b0, 32'h0);
        cnt = 0;
        for (int k = 1; k <= last_lat && k <= 8; k++) if (s_addr[k] == 22'h3FFFFF) cnt++;
        check("stdio_addr_cycles", 32'(cnt), 32'd1);
        check("stdio_a1_wlo", 32'(s_wlo[1]), 32'd1);
        check("stdio_a1_olo", 32'(s_olo[1]), 32'd1);
        check("stdio_d1_addr", 32'(s_addr[2]), 32'h0);
        check("stdio_d1_olo", 32'(s_olo[2]), 32'd0);
        check("stdio_char", last_rd, 32'h00000041);

        // Reset during the data phase of a store.
        op(24'h000300, 2'd2, 1'b1, 1'b0, 32'h12345678);
        req_valid = 1'b1; req_addr = 24'h000300; req_size = 2'd2;
        req_write = 1'b1; req_signed = 1'b0; req_wdata = 32'hCAFEF00D;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("abort_d1_wmask", 32'(mem_wmask), 32'h0);
        #2 resetlo = 1'b0;
        #1;
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_wmask", 32'(mem_wmask), 32'hF);
        check("abort_addr", 32'(mem_address), 32'h0);
        check("abort_wlo", 32'(mem_wlo), 32'd1);
        check("abort_olo", 32'(mem_olo), 32'd1);
        check("abort_wdata", mem_wdata, 32'h0);
        check("abort_resp", 32'(resp_valid), 32'd0);
        @(negedge clock);
        resetlo = 1'b1;
        cnt = 0;
        repeat (4) begin
            @(negedge clock);
            if (resp_valid) cnt++;
        end
        check("abort_no_resp", 32'(cnt), 32'd0);
        check("abort_mem_unchanged", mem_q[widx(22'h0000C0)], 32'h12345678);
        op(24'h000300, 2'd2, 1'b0, 1'b0, 32'h0);
        check("after_abort_load", last_rd, 32'h12345678);

        // Randomized back-to-back traffic.
        for (int n = 0; n < 200; n++) begin
            ra = $urandom_range(0, 1) ? (24'h000400 + 24'($urandom_range(0, 31)))
                                      : (24'hFFFFF8 + 24'($urandom_range(0, 7)));
            op(ra, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom);
        end

        bad = 0;
        foreach (rmem[k]) begin
            ba = k[23:0];
            w = mem_q[widx(ba[23:2])];
            if (w[8*ba[1:0] +: 8] !== rmem[k]) bad++;
        end
        check("mem_image", 32'(bad), 32'd0);
        check("stray_writes", 32'(stray_q), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
